// File: rtl/postfix_pkg.sv
// postfix_pkg: shared opcodes, error codes and state/token enums for the postfix evaluator
package postfix_pkg;

    localparam logic [7:0] OP_ADD = 8'h2B;
    localparam logic [7:0] OP_SUB = 8'h2D;
    localparam logic [7:0] OP_MUL = 8'h2A;
    localparam logic [7:0] OP_DIV = 8'h2F;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_OVF   = 3'd1;
    localparam logic [2:0] ERR_UNDER = 3'd2;
    localparam logic [2:0] ERR_DIVZ  = 3'd3;
    localparam logic [2:0] ERR_BADOP = 3'd4;
    localparam logic [2:0] ERR_UNBAL = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DIV, S_HOLD} state_t;

    typedef enum logic [1:0] {TK_NUM, TK_OP, TK_END} tok_t;

    function automatic logic is_op(input logic [7:0] c);
        return (c == OP_ADD) || (c == OP_SUB) || (c == OP_MUL) || (c == OP_DIV);
    endfunction

endpackage

// File: rtl/postfix_div.sv
// postfix_div: sequential signed restoring divider, one quotient bit per cycle, truncating toward zero
module postfix_div #(
    parameter int DATA_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] quotient,
    output logic              done
);

    localparam int CW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] q_q, d_q, r_q;
    logic [DATA_W-1:0] a_mag, b_mag;
    logic [DATA_W:0]   r_sh, r_sub;
    logic [CW-1:0]     cnt_q;
    logic              neg_q, run_q, done_q;

    // Magnitudes of the operands and the trial subtraction for the current bit
    always_comb begin
        a_mag    = a[DATA_W-1] ? -a : a;
        b_mag    = b[DATA_W-1] ? -b : b;
        r_sh     = {r_q, q_q[DATA_W-1]};
        r_sub    = r_sh - {1'b0, d_q};
        quotient = neg_q ? -q_q : q_q;
        done     = done_q;
    end

    // Load on start, then shift one dividend bit into the remainder per cycle
    always_ff @(posedge CLK) begin
        if (RST) begin
            q_q    <= '0;
            d_q    <= '0;
            r_q    <= '0;
            cnt_q  <= '0;
            neg_q  <= 1'b0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                q_q   <= a_mag;
                d_q   <= b_mag;
                r_q   <= '0;
                neg_q <= a[DATA_W-1] ^ b[DATA_W-1];
                cnt_q <= CW'(DATA_W);
                run_q <= 1'b1;
            end else if (run_q) begin
                q_q   <= {q_q[DATA_W-2:0], ~r_sub[DATA_W]};
                r_q   <= r_sub[DATA_W] ? r_sh[DATA_W-1:0] : r_sub[DATA_W-1:0];
                cnt_q <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/postfix_eval.sv
// postfix_eval: stack evaluator for a postfix token stream with strobe/BUSY handshake
module postfix_eval
    import postfix_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        SIGN_IN,
    input  logic [7:0]        NUMBER_IN,
    input  logic              SIGN_STB,
    input  logic              NUMBER_STB,
    output logic              BUSY,
    output logic [DATA_W-1:0] RESULT,
    output logic              RESULT_STB,
    output logic [2:0]        ERROR
);

    localparam int PW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    state_t            state_q;
    tok_t              kind_q;
    logic [7:0]        sign_q, num_q;
    logic [DATA_W-1:0] stk_q [DEPTH];
    logic [PW-1:0]     sp_q;
    logic [2:0]        err_q, error_q;
    logic [DATA_W-1:0] result_q;
    logic              result_stb_q, div_start_q;
    logic [AW-1:0]     i_top, i_nxt, i_push;
    logic [DATA_W-1:0] tos, nos, alu, num_ext, div_quo;
    logic              div_done;

    postfix_div #(.DATA_W(DATA_W)) u_div (
        .CLK      (CLK),
        .RST      (RST),
        .start    (div_start_q),
        .a        (nos),
        .b        (tos),
        .quotient (div_quo),
        .done     (div_done)
    );

    // Combinational reads of top/next and the non-divide arithmetic result
    always_comb begin
        i_top   = AW'(sp_q - PW'(1));
        i_nxt   = AW'(sp_q - PW'(2));
        i_push  = AW'(sp_q);
        tos     = stk_q[i_top];
        nos     = stk_q[i_nxt];
        num_ext = {{(DATA_W-8){1'b0}}, num_q};
        alu     = (sign_q == OP_ADD) ? nos + tos : (sign_q == OP_SUB) ? nos - tos : nos * tos;
    end

    assign BUSY       = (state_q != S_IDLE);
    assign RESULT     = result_q;
    assign RESULT_STB = result_stb_q;
    assign ERROR      = error_q;

    // Token capture, stack update, error latch and result presentation
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            kind_q       <= TK_NUM;
            sign_q       <= '0;
            num_q        <= '0;
            sp_q         <= '0;
            err_q        <= ERR_NONE;
            error_q      <= ERR_NONE;
            result_q     <= '0;
            result_stb_q <= 1'b0;
            div_start_q  <= 1'b0;
        end else begin
            result_stb_q <= 1'b0;
            div_start_q  <= 1'b0;
            case (state_q)
                S_IDLE: if (SIGN_STB || NUMBER_STB) begin
                    kind_q  <= (SIGN_STB && NUMBER_STB) ? TK_END : SIGN_STB ? TK_OP : TK_NUM;
                    sign_q  <= SIGN_IN;
                    num_q   <= NUMBER_IN;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    state_q <= S_HOLD;
                    if (kind_q == TK_END) begin
                        result_stb_q <= 1'b1;
                        result_q     <= (err_q == ERR_NONE && sp_q == PW'(1)) ? tos : '0;
                        error_q      <= (err_q != ERR_NONE) ? err_q : (sp_q == PW'(1)) ? ERR_NONE : ERR_UNBAL;
                        sp_q         <= '0;
                        err_q        <= ERR_NONE;
                    end else if (err_q == ERR_NONE) begin
                        if (kind_q == TK_NUM) begin
                            if (sp_q == PW'(DEPTH)) begin
                                err_q <= ERR_OVF;
                            end else begin
                                stk_q[i_push] <= num_ext;
                                sp_q          <= sp_q + PW'(1);
                            end
                        end else if (!is_op(sign_q)) begin
                            err_q <= ERR_BADOP;
                        end else if (sp_q < PW'(2)) begin
                            err_q <= ERR_UNDER;
                        end else if (sign_q == OP_DIV) begin
                            if (tos == '0) begin
                                err_q <= ERR_DIVZ;
                            end else begin
                                div_start_q <= 1'b1;
                                state_q     <= S_DIV;
                            end
                        end else begin
                            stk_q[i_nxt] <= alu;
                            sp_q         <= sp_q - PW'(1);
                        end
                    end
                end
                S_DIV: if (div_done) begin
                    stk_q[i_nxt] <= div_quo;
                    sp_q         <= sp_q - PW'(1);
                    state_q      <= S_HOLD;
                end
                S_HOLD: if (!SIGN_STB && !NUMBER_STB) state_q <= S_IDLE;
            endcase
        end
    end

endmodule
